// File: rtl/rgbw_pkg.sv
// -----------------------------------------------------------------------------
// rgbw_pkg
// Shared definitions for the four-channel RGBW PWM generator.
//   PWM_WIDTH      : counter / duty width in bits
//   PWM_TOP_DEF    : default terminal count (period = PWM_TOP_DEF + 1 ticks)
//   NUM_CH         : number of LED channels
//   PHASE_STEP_DEF : default per-channel counter offset, used only when
//                    RGBW_PWM_PHASE_SHIFT_EN is defined
//   duty_t         : one channel's duty value
//   ch_e           : channel index (red, green, blue, white)
//   phase_wrap     : folds a 9-bit counter+offset sum back into one period
// -----------------------------------------------------------------------------
package rgbw_pkg;

  localparam int PWM_WIDTH      = 8;
  localparam int PWM_TOP_DEF    = 254;
  localparam int NUM_CH         = 4;
  localparam int PHASE_STEP_DEF = 64;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2,
    CH_WHITE = 2'd3
  } ch_e;

  // Both operands stay below two periods, so one conditional subtraction
  // is enough to bring the sum back into 0..period-1.
  function automatic duty_t phase_wrap(input logic [PWM_WIDTH:0] sum,
                                       input logic [PWM_WIDTH:0] period);
    logic [PWM_WIDTH:0] res;
    if (sum >= period) begin
      res = sum - period;
    end else begin
      res = sum;
    end
    return res[PWM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rgbw_pwm_channel.sv
// -----------------------------------------------------------------------------
// rgbw_pwm_channel
// One PWM channel: staging register (written by the duty strobe), shadow
// register (loaded at a period boundary) and the registered compare that
// drives the LED pin.
// Optional macro RGBW_PWM_PHASE_SHIFT_EN adds a fixed counter offset per
// channel so rising edges are staggered across the period.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   duty_vld : captures duty_in into staging
//   duty_in  : new duty value for this channel
//   load     : period boundary with a staged set pending; shadow <= staging
//   cnt      : shared period counter
//   pwm      : registered PWM output
// -----------------------------------------------------------------------------
module rgbw_pwm_channel
  import rgbw_pkg::*;
`ifdef RGBW_PWM_PHASE_SHIFT_EN
#(
  parameter int PWM_TOP      = PWM_TOP_DEF,
  parameter int PHASE_OFFSET = 0
)
`endif
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 duty_vld,
  input  logic [PWM_WIDTH-1:0] duty_in,
  input  logic                 load,
  input  logic [PWM_WIDTH-1:0] cnt,
  output logic                 pwm
);

  duty_t                staging_r;
  duty_t                shadow_r;
  logic [PWM_WIDTH-1:0] cnt_ch_s;
  logic                 pwm_r;

  // Staging capture: every strobe overwrites, the last one before a wrap wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging_r <= {PWM_WIDTH{1'b0}};
    end else if (duty_vld) begin
      staging_r <= duty_in;
    end else begin
      staging_r <= staging_r;
    end
  end

  // Shadow load at the period boundary; takes the pre-strobe staging value
  // when a strobe lands on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r <= {PWM_WIDTH{1'b0}};
    end else if (load) begin
      shadow_r <= staging_r;
    end else begin
      shadow_r <= shadow_r;
    end
  end

`ifdef RGBW_PWM_PHASE_SHIFT_EN
  localparam logic [PWM_WIDTH:0] PERIOD9 = (PWM_WIDTH+1)'(PWM_TOP + 1);
  localparam logic [PWM_WIDTH:0] OFFS9   = (PWM_WIDTH+1)'(PHASE_OFFSET);

  // Channel-local count: shared counter shifted by this channel's offset.
  always_comb begin
    cnt_ch_s = phase_wrap({1'b0, cnt} + OFFS9, PERIOD9);
  end
`else
  // Channel-local count: all channels share the un-offset counter.
  always_comb begin
    cnt_ch_s = cnt;
  end
`endif

  // Registered compare; runs every clock so the pin follows the shadow
  // even while the counter is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= (cnt_ch_s < shadow_r);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/rgbw_pwm_gen.sv
// -----------------------------------------------------------------------------
// rgbw_pwm_gen
// Four-channel double-buffered PWM generator for an RGBW LED. Duty sets
// captured on duty_vld are applied only at a period boundary.
// Optional macro RGBW_PWM_PHASE_SHIFT_EN staggers the channels by
// PHASE_STEP counts (0/64/128/192 by default).
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   tick         : counter enable from the prescaler
//   duty_vld     : one-cycle strobe capturing duty0..duty3
//   duty0..duty3 : red / green / blue / white duty values
//   d0..d3       : red / green / blue / white PWM pins (registered)
//   pending      : a staged duty set waits for the next period boundary
//   period_start : one-clock pulse after the counter wraps to 0
// -----------------------------------------------------------------------------
module rgbw_pwm_gen
  import rgbw_pkg::*;
#(
  parameter int PWM_TOP = PWM_TOP_DEF
`ifdef RGBW_PWM_PHASE_SHIFT_EN
  ,
  parameter int PHASE_STEP = PHASE_STEP_DEF
`endif
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       duty_vld,
  input  logic [7:0] duty0,
  input  logic [7:0] duty1,
  input  logic [7:0] duty2,
  input  logic [7:0] duty3,
  output logic       d0,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       pending,
  output logic       period_start
);

  localparam logic [PWM_WIDTH-1:0] TOP_VAL = PWM_WIDTH'(PWM_TOP);

  logic [PWM_WIDTH-1:0] cnt_r;
  logic                 pending_r;
  logic                 period_start_r;
  logic                 wrap_s;
  logic                 load_s;
  logic [PWM_WIDTH-1:0] duty_s [NUM_CH];
  logic [NUM_CH-1:0]    pwm_s;

  assign wrap_s = tick & (cnt_r == TOP_VAL);
  // Transfer uses the registered pending flag, so a strobe on the wrap edge
  // itself is held back for the following period.
  assign load_s = wrap_s & pending_r;

  // Period counter: advances on tick, wraps at PWM_TOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {PWM_WIDTH{1'b0}};
    end else if (tick) begin
      if (cnt_r == TOP_VAL) begin
        cnt_r <= {PWM_WIDTH{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(PWM_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Period-start pulse, high in the cycle after the counter returns to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_start_r <= 1'b0;
    end else begin
      period_start_r <= wrap_s;
    end
  end

  // Pending flag: a strobe always wins over the clear at a wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if (duty_vld) begin
      pending_r <= 1'b1;
    end else if (wrap_s) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign duty_s[CH_RED]   = duty0;
  assign duty_s[CH_GREEN] = duty1;
  assign duty_s[CH_BLUE]  = duty2;
  assign duty_s[CH_WHITE] = duty3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rgbw_pwm_channel
`ifdef RGBW_PWM_PHASE_SHIFT_EN
    #(
      .PWM_TOP      (PWM_TOP),
      .PHASE_OFFSET (g * PHASE_STEP)
    )
`endif
    u_ch (
      .clk      (clk),
      .reset    (reset),
      .duty_vld (duty_vld),
      .duty_in  (duty_s[g]),
      .load     (load_s),
      .cnt      (cnt_r),
      .pwm      (pwm_s[g])
    );
  end

  assign d0           = pwm_s[CH_RED];
  assign d1           = pwm_s[CH_GREEN];
  assign d2           = pwm_s[CH_BLUE];
  assign d3           = pwm_s[CH_WHITE];
  assign pending      = pending_r;
  assign period_start = period_start_r;

endmodule

// File: tb/tb_rgbw_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_rgbw_pwm_gen
// Self-checking bench for rgbw_pwm_gen: table of duty sets with expected
// high counts per period, plus hand-written sequences for mid-period
// strobes, strobe-on-wrap, slow tick, reset mid-period and (with
// RGBW_PWM_PHASE_SHIFT_EN) staggered rising edges.
// -----------------------------------------------------------------------------
module tb_rgbw_pwm_gen;

  logic       clk = 1'b0;
  logic       reset, tick, duty_vld;
  logic [7:0] duty0, duty1, duty2, duty3;
  logic       d0, d1, d2, d3, pending, period_start;
  logic [3:0] dv;

  always #5 clk = ~clk;

  assign dv = {d3, d2, d1, d0};

  rgbw_pwm_gen dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .duty_vld     (duty_vld),
    .duty0        (duty0),
    .duty1        (duty1),
    .duty2        (duty2),
    .duty3        (duty3),
    .d0           (d0),
    .d1           (d1),
    .d2           (d2),
    .d3           (d3),
    .pending      (pending),
    .period_start (period_start)
  );

  typedef struct packed {
    logic [3:0][7:0] duty;
    logic [3:0][8:0] exp_hi;
  } vec_t;

  vec_t tbl [3];

  int   n_chk = 0;
  int   n_fail = 0;
  int   tick_mode = 0;
  int   phase = 0;
  int   hi_cnt [4];
  int   first_hi [4];
  int   pend_lo, steps_taken, ps_seen;
  logic last_ps, last_pend;

  task automatic check(input string name, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic apply_tick();
    case (tick_mode)
      0:       tick = 1'b1;
      1:       tick = ((phase % 4) == 0);
      default: tick = 1'b0;
    endcase
  endtask

  task automatic set_mode(input int m);
    tick_mode = m;
    apply_tick();
  endtask

  // One clock: sample 1 time unit after the edge, then set tick for the next.
  task automatic step();
    @(posedge clk);
    #1;
    phase = phase + 1;
    apply_tick();
  endtask

  task automatic step_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic strobe(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] e);
    duty0 = a; duty1 = b; duty2 = c; duty3 = e;
    duty_vld = 1'b1;
    step();
    duty_vld = 1'b0;
  endtask

  // Step until period_start is seen; counts highs and pending-low samples
  // strictly before that sample.
  task automatic wait_ps(input string name, input int bound);
    int found;
    found = 0;
    steps_taken = 0;
    pend_lo = 0;
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    while (found == 0 && steps_taken < bound) begin
      step();
      steps_taken = steps_taken + 1;
      if (period_start) begin
        found = 1;
      end else begin
        for (int c = 0; c < 4; c++) if (dv[c]) hi_cnt[c] = hi_cnt[c] + 1;
        if (!pending) pend_lo = pend_lo + 1;
      end
    end
    check({name, "_ps_reached"}, found, 1);
  endtask

  // Count highs per channel over n samples starting right after a wrap.
  task automatic measure(input int n);
    ps_seen = 0;
    for (int c = 0; c < 4; c++) begin
      hi_cnt[c] = 0;
      first_hi[c] = -1;
    end
    for (int j = 1; j <= n; j++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        if (dv[c]) begin
          hi_cnt[c] = hi_cnt[c] + 1;
          if (first_hi[c] < 0) first_hi[c] = j - 1;
        end
      end
      if (period_start) ps_seen = ps_seen + 1;
    end
    last_ps = period_start;
    last_pend = pending;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; duty_vld = 1'b0;
    duty0 = 8'd0; duty1 = 8'd0; duty2 = 8'd0; duty3 = 8'd0;

    tbl[0].duty = {8'd1, 8'd128, 8'd255, 8'd0};     tbl[0].exp_hi = {9'd1, 9'd128, 9'd255, 9'd0};
    tbl[1].duty = {8'd254, 8'd200, 8'd10, 8'd64};   tbl[1].exp_hi = {9'd254, 9'd200, 9'd10, 9'd64};
    tbl[2].duty = {8'd128, 8'd1, 8'd0, 8'd255};     tbl[2].exp_hi = {9'd128, 9'd1, 9'd0, 9'd255};

    // Reset state
    step_n(2);
    check("rst_d", int'(dv), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_period_start", int'(period_start), 0);
    reset = 1'b0;
    set_mode(0);
    step_n(3);

    // Table: strobe early in a period, skip to wrap, measure the next period
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step_n(5);
      strobe(tbl[i].duty[0], tbl[i].duty[1], tbl[i].duty[2], tbl[i].duty[3]);
      wait_ps($sformatf("tbl%0d", i), 600);
      if (i == 0) begin
        for (int c = 0; c < 4; c++) check($sformatf("first_period_d%0d", c), hi_cnt[c], 0);
        check("first_period_pending_low", pend_lo, 0);
      end
      measure(255);
      for (int c = 0; c < 4; c++)
        check($sformatf("tbl%0d_hi_d%0d", i, c), hi_cnt[c], int'(tbl[i].exp_hi[c]));
      check($sformatf("tbl%0d_ps_count", i), ps_seen, 1);
      check($sformatf("tbl%0d_ps_last", i), int'(last_ps), 1);
    end

    // Mid-period strobe at cnt=100 while d0 runs at 255
    step_n(100);
    strobe(8'd64, 8'd10, 8'd200, 8'd254);
    check("mid_pending_set", int'(pending), 1);
    wait_ps("mid", 600);
    check("mid_steps_to_wrap", steps_taken, 154);
    check("mid_old_d0_high", hi_cnt[0], steps_taken - 1);
    check("mid_pending_low", pend_lo, 0);
    check("mid_pending_cleared", int'(pending), 0);
    measure(255);
    check("mid_new_d0", hi_cnt[0], 64);
    check("mid_new_d3", hi_cnt[3], 254);

    // Strobe on the wrap edge with A already staged
    step_n(5);
    strobe(8'd10, 8'd20, 8'd30, 8'd40);
    step_n(248);
    check("coll_pre_ps", int'(period_start), 0);
    strobe(8'd200, 8'd210, 8'd220, 8'd230);
    check("coll_wrap_ps", int'(period_start), 1);
    check("coll_pending_kept", int'(pending), 1);
    measure(255);
    check("coll_A_d0", hi_cnt[0], 10);
    check("coll_A_d3", hi_cnt[3], 40);
    check("coll_ps2", int'(last_ps), 1);
    check("coll_pending_after2", int'(last_pend), 0);
    measure(255);
    check("coll_B_d0", hi_cnt[0], 200);
    check("coll_B_d1", hi_cnt[1], 210);
    check("coll_B_d3", hi_cnt[3], 230);

    // Tick every 4th clock, duty 50
    step_n(5);
    strobe(8'd50, 8'd50, 8'd50, 8'd50);
    set_mode(1);
    wait_ps("slow", 2000);
    measure(1020);
    for (int c = 0; c < 4; c++) check($sformatf("slow_hi_d%0d", c), hi_cnt[c], 200);
    check("slow_ps_count", ps_seen, 1);
    check("slow_ps_last", int'(last_ps), 1);

    // Reset at cnt=150 with a staged set pending
    set_mode(0);
    step_n(10);
    strobe(8'd99, 8'd99, 8'd99, 8'd99);
    step_n(139);
    check("rst2_pending_before", int'(pending), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst2_d", int'(dv), 0);
    check("rst2_pending", int'(pending), 0);
    check("rst2_ps", int'(period_start), 0);
    wait_ps("rst2", 600);
    check("rst2_steps_to_wrap", steps_taken, 255);
    check("rst2_pending_low_count", pend_lo, steps_taken - 1);
    measure(255);
    for (int c = 0; c < 4; c++) check($sformatf("rst2_hi_d%0d", c), hi_cnt[c], 0);

`ifdef RGBW_PWM_PHASE_SHIFT_EN
    // Staggered rising edges, all duties 32
    step_n(5);
    strobe(8'd32, 8'd32, 8'd32, 8'd32);
    wait_ps("phase", 600);
    measure(255);
    check("phase_rise_d0", first_hi[0], 0);
    check("phase_rise_d1", first_hi[1], 191);
    check("phase_rise_d2", first_hi[2], 127);
    check("phase_rise_d3", first_hi[3], 63);
    for (int c = 0; c < 4; c++) check($sformatf("phase_hi_d%0d", c), hi_cnt[c], 32);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
